// File: rtl/acc_req_queue_pkg.sv
// Shared types and sizing for the per-core accumulator request queue.
// The empty-lane stamp sentinel helper lives here so consumers can reuse it.
package acc_req_queue_pkg;
   localparam int N_ACC    = 3;
   localparam int DEPTH    = 4;
   localparam int GC_WIDTH = 16;
   localparam int LANE_W   = (N_ACC > 1) ? $clog2(N_ACC) : 1;

   typedef struct packed {
      logic [31:0]         data;
      logic [GC_WIDTH-1:0] gc;
   } acc_entry_t;

   // Stamp that loses every strict compare at the consumer for the given direction.
   function automatic logic [GC_WIDTH-1:0] empty_stamp(input logic gd_sign);
      logic [GC_WIDTH-1:0] most_neg;
      most_neg = {1'b1, {(GC_WIDTH-1){1'b0}}};
      return gd_sign ? most_neg : ~most_neg;
   endfunction
endpackage

// File: rtl/acc_lane_fifo.sv
// One accumulator lane: circular FIFO with wrap-bit pointers and a combinational head.
// Pointers clear asynchronously; storage is never reset.
module acc_lane_fifo
   import acc_req_queue_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       flush,
   input  logic       push,
   input  acc_entry_t push_entry,
   input  logic       pop,
   output logic       full,
   output logic       empty,
   output acc_entry_t head
);
   localparam int AW = $clog2(DEPTH);

   logic [AW:0] wr_ptr_reg;
   logic [AW:0] rd_ptr_reg;
   acc_entry_t  mem [DEPTH];

   logic do_push;
   logic do_pop;

   assign empty   = (wr_ptr_reg == rd_ptr_reg);
   assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                    (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr_reg[AW-1:0]];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else if (flush) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr_reg[AW-1:0]] <= push_entry;
   end
endmodule

// File: rtl/acc_req_queue.sv
// Per-core accumulator request buffer: one FIFO per lane, heads presented with GC stamps.
// Empty lanes present a sentinel stamp and zero data so they never win arbitration.
module acc_req_queue
   import acc_req_queue_pkg::*;
(
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic                           flush,
   input  logic                           push_valid,
   output logic                           push_ready,
   input  logic [LANE_W-1:0]              push_lane,
   input  logic [31:0]                    push_data,
   input  logic [GC_WIDTH-1:0]            push_gc,
   input  logic                           gd_sign,
   output logic [N_ACC-1:0]               acc_req_valid,
   input  logic [N_ACC-1:0]               acc_req_ready,
   output logic [N_ACC-1:0][31:0]         acc_data,
   output logic [N_ACC-1:0][GC_WIDTH-1:0] gc_stamp,
   output logic                           empty,
   output logic                           lane_err
);
   logic [N_ACC-1:0] lane_full;
   logic [N_ACC-1:0] lane_empty;
   acc_entry_t       lane_head [N_ACC];
   acc_entry_t       push_entry;
   logic             full_sel;
   logic             lane_ok;
   logic             lane_err_reg;

   assign push_entry = '{data: push_data, gc: push_gc};
   assign lane_ok    = ({1'b0, push_lane} < (LANE_W+1)'(N_ACC));

   // An out-of-range lane matches no FIFO, so it reads as not-full and is accepted then dropped.
   always_comb begin
      full_sel = 1'b0;
      for (int i = 0; i < N_ACC; i++) begin
         if (push_lane == LANE_W'(i)) full_sel = lane_full[i];
      end
   end
   assign push_ready = !full_sel;

   genvar gi;
   generate
      for (gi = 0; gi < N_ACC; gi++) begin : g_lane
         acc_lane_fifo #(.DEPTH(DEPTH)) u_fifo (
            .clk        (clk),
            .reset_n    (reset_n),
            .flush      (flush),
            .push       (push_valid && (push_lane == LANE_W'(gi))),
            .push_entry (push_entry),
            .pop        (acc_req_ready[gi]),
            .full       (lane_full[gi]),
            .empty      (lane_empty[gi]),
            .head       (lane_head[gi])
         );

         assign acc_req_valid[gi] = !lane_empty[gi];
         assign acc_data[gi]      = lane_empty[gi] ? 32'h0 : lane_head[gi].data;
         assign gc_stamp[gi]      = lane_empty[gi] ? empty_stamp(gd_sign) : lane_head[gi].gc;
      end
   endgenerate

   assign empty = &lane_empty;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                    lane_err_reg <= 1'b0;
      else if (push_valid && !lane_ok) lane_err_reg <= 1'b1;
   end
   assign lane_err = lane_err_reg;
endmodule

// File: tb/tb_acc_req_queue.sv
// Directed self-checking bench for acc_req_queue (N_ACC=3, DEPTH=4, GC_WIDTH=16).
// Outputs are sampled 2 time units after the rising edge; combinational ones 1 unit after input changes.
module tb_acc_req_queue;
   import acc_req_queue_pkg::*;

   logic                           clk = 1'b0;
   logic                           reset_n;
   logic                           flush;
   logic                           push_valid;
   logic                           push_ready;
   logic [LANE_W-1:0]              push_lane;
   logic [31:0]                    push_data;
   logic [GC_WIDTH-1:0]            push_gc;
   logic                           gd_sign;
   logic [N_ACC-1:0]               acc_req_valid;
   logic [N_ACC-1:0]               acc_req_ready;
   logic [N_ACC-1:0][31:0]         acc_data;
   logic [N_ACC-1:0][GC_WIDTH-1:0] gc_stamp;
   logic                           empty;
   logic                           lane_err;

   int total = 0;
   int bad   = 0;

   acc_req_queue dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .flush         (flush),
      .push_valid    (push_valid),
      .push_ready    (push_ready),
      .push_lane     (push_lane),
      .push_data     (push_data),
      .push_gc       (push_gc),
      .gd_sign       (gd_sign),
      .acc_req_valid (acc_req_valid),
      .acc_req_ready (acc_req_ready),
      .acc_data      (acc_data),
      .gc_stamp      (gc_stamp),
      .empty         (empty),
      .lane_err      (lane_err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
      $display("check %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic set_push(input logic v, input logic [LANE_W-1:0] lane,
                           input logic [31:0] d, input logic [GC_WIDTH-1:0] g);
      push_valid = v;
      push_lane  = lane;
      push_data  = d;
      push_gc    = g;
   endtask

   initial begin
      reset_n = 1'b0; flush = 1'b0; gd_sign = 1'b1; acc_req_ready = '0;
      set_push(1'b0, 2'd0, 32'h0, 16'h0);
      #1;
      chk("rst_valid", 32'(acc_req_valid), 32'h0);
      chk("rst_empty", 32'(empty), 32'h1);
      chk("rst_lane_err", 32'(lane_err), 32'h0);
      chk("rst_push_ready", 32'(push_ready), 32'h1);
      tick(); tick();
      reset_n = 1'b1;
      tick();

      // 1: single push into lane1, one-cycle latency, sentinels on other lanes
      set_push(1'b1, 2'd1, 32'h3F80_0000, 16'd5);
      #1;
      chk("t1_no_bypass", 32'(acc_req_valid), 32'h0);
      tick();
      set_push(1'b0, 2'd0, 32'h0, 16'h0);
      #1;
      chk("t1_valid", 32'(acc_req_valid), 32'h2);
      chk("t1_gc1", 32'(gc_stamp[1]), 32'd5);
      chk("t1_data1", acc_data[1], 32'h3F80_0000);
      chk("t1_sent0_pos", 32'(gc_stamp[0]), 32'h8000);
      chk("t1_sent2_pos", 32'(gc_stamp[2]), 32'h8000);
      chk("t1_data0_zero", acc_data[0], 32'h0);
      gd_sign = 1'b0;
      #1;
      chk("t1_sent0_neg", 32'(gc_stamp[0]), 32'h7FFF);
      chk("t1_sent2_neg", 32'(gc_stamp[2]), 32'h7FFF);
      acc_req_ready = 3'b010;
      tick();
      acc_req_ready = 3'b000;
      #1;
      chk("t1_drained", 32'(empty), 32'h1);

      // 2: fill lane0, lane0 refuses while lane2 still accepts
      for (int i = 0; i < DEPTH; i++) begin
         set_push(1'b1, 2'd0, 32'd100 + 32'(i), 16'd10 + 16'(i));
         tick();
      end
      #1;
      chk("t2_lane0_full_ready", 32'(push_ready), 32'h0);
      set_push(1'b1, 2'd2, 32'hAA, 16'd77);
      #1;
      chk("t2_lane2_ready", 32'(push_ready), 32'h1);
      tick();
      set_push(1'b0, 2'd0, 32'h0, 16'h0);
      #1;
      chk("t2_valid", 32'(acc_req_valid), 32'h5);
      chk("t2_gc2", 32'(gc_stamp[2]), 32'd77);
      acc_req_ready = 3'b100;
      tick();
      acc_req_ready = 3'b000;

      // 3: full lane0 with simultaneous pop: pop happens, push refused this cycle
      set_push(1'b1, 2'd0, 32'd104, 16'd14);
      acc_req_ready = 3'b001;
      #1;
      chk("t3_ready_full_pop", 32'(push_ready), 32'h0);
      chk("t3_head_before", 32'(gc_stamp[0]), 32'd10);
      tick();
      acc_req_ready = 3'b000;
      #1;
      chk("t3_ready_after_pop", 32'(push_ready), 32'h1);
      chk("t3_head_after", 32'(gc_stamp[0]), 32'd11);
      tick();
      #1;
      chk("t3_full_again", 32'(push_ready), 32'h0);
      set_push(1'b0, 2'd0, 32'h0, 16'h0);
      for (int i = 0; i < DEPTH; i++) begin
         #1;
         chk($sformatf("t3_drain_gc%0d", i), 32'(gc_stamp[0]), 32'd11 + 32'(i));
         chk($sformatf("t3_drain_data%0d", i), acc_data[0], 32'd101 + 32'(i));
         acc_req_ready = 3'b001;
         tick();
      end
      acc_req_ready = 3'b000;
      #1;
      chk("t3_lane0_empty", 32'(acc_req_valid), 32'h0);

      // 4: stream 2*DEPTH+1 entries through lane2 across pointer wraps
      set_push(1'b1, 2'd2, 32'h5000, 16'd200);
      tick();
      for (int k = 1; k <= 2 * DEPTH; k++) begin
         set_push(1'b1, 2'd2, 32'h5000 + 32'(k), 16'd200 + 16'(k));
         acc_req_ready = 3'b100;
         #1;
         chk($sformatf("t4_gc%0d", k - 1), 32'(gc_stamp[2]), 32'd200 + 32'(k - 1));
         chk($sformatf("t4_data%0d", k - 1), acc_data[2], 32'h5000 + 32'(k - 1));
         tick();
      end
      set_push(1'b0, 2'd0, 32'h0, 16'h0);
      #1;
      chk("t4_last_gc", 32'(gc_stamp[2]), 32'd208);
      tick();
      acc_req_ready = 3'b000;
      #1;
      chk("t4_empty", 32'(empty), 32'h1);

      // 5: two entries per lane, then flush with a concurrent push
      for (int l = 0; l < N_ACC; l++) begin
         for (int j = 0; j < 2; j++) begin
            set_push(1'b1, LANE_W'(l), 32'(l * 16 + j), 16'(l * 16 + j));
            tick();
         end
      end
      set_push(1'b0, 2'd0, 32'h0, 16'h0);
      #1;
      chk("t5_all_valid", 32'(acc_req_valid), 32'h7);
      chk("t5_not_empty", 32'(empty), 32'h0);
      flush = 1'b1;
      set_push(1'b1, 2'd0, 32'hDEAD, 16'd99);
      tick();
      flush = 1'b0;
      set_push(1'b0, 2'd0, 32'h0, 16'h0);
      #1;
      chk("t5_flush_empty", 32'(empty), 32'h1);
      chk("t5_flush_valid", 32'(acc_req_valid), 32'h0);
      tick();
      chk("t5_push_absent", 32'(acc_req_valid), 32'h0);

      // 6: out-of-range lane sets sticky error; only reset clears it
      set_push(1'b1, 2'd3, 32'hBEEF, 16'd1);
      #1;
      chk("t6_ready_bad_lane", 32'(push_ready), 32'h1);
      tick();
      set_push(1'b0, 2'd0, 32'h0, 16'h0);
      #1;
      chk("t6_lane_err", 32'(lane_err), 32'h1);
      chk("t6_no_entry", 32'(acc_req_valid), 32'h0);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("t6_err_after_flush", 32'(lane_err), 32'h1);
      set_push(1'b1, 2'd0, 32'h1234, 16'd3);
      tick();
      set_push(1'b0, 2'd0, 32'h0, 16'h0);
      #1;
      chk("t6_pre_reset_valid", 32'(acc_req_valid), 32'h1);
      reset_n = 1'b0;
      #1;
      chk("t6_async_valid", 32'(acc_req_valid), 32'h0);
      chk("t6_err_cleared", 32'(lane_err), 32'h0);
      tick();
      reset_n = 1'b1;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
